hop_scan_rx: RTL and testbench

//  Receiving end of the two-phase hop-control scan chain. Decodes scan_id/scan_phi/scan_phi_bar/

---
 rtl/hop_scan_rx.sv | 146 ++++++++++++++
 tb/tb_hop_scan_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hop_scan_rx.sv
// rtl/hop_scan_rx.sv - hop-control scan chain receiver: two-phase deserialiser, commit and protocol checks
module hop_scan_rx #(
  parameter int NTX_BITS      = 58,
  parameter int BIT_CNT_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     scan_id,
  input  logic                     scan_phi,
  input  logic                     scan_phi_bar,
  input  logic                     scan_data_in,
  input  logic                     scan_load_chip,
  output logic [NTX_BITS-1:0]      data_out,
  output logic                     data_valid,
  output logic [BIT_CNT_WIDTH-1:0] nbits_cnt,
  output logic [1:0]               rx_state,
  output logic                     err_seq,
  output logic                     err_count,
  output logic                     err_abort
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PHI  = 2'd1,
    WAIT_PHIB = 2'd2
  } state_t;

  localparam logic [BIT_CNT_WIDTH-1:0] FULL = BIT_CNT_WIDTH'(NTX_BITS);

  // control bits packed as {load, phi_bar, phi, id}; data only needs one stage
  logic [3:0]          s1_ctl, s2_ctl, rise;
  logic                s1_data;
  logic                rise_id, rise_phi, rise_phib, rise_load, multi_rise;

  state_t              state, state_n;
  logic [NTX_BITS-1:0] sr, sr_n, data_out_n;
  logic                master, master_n;
  logic                committed, committed_n;
  logic [BIT_CNT_WIDTH-1:0] cnt_n;
  logic                valid_n, seq_n, count_n, abort_n;

  assign rise       = s1_ctl & ~s2_ctl;
  assign rise_id    = rise[0];
  assign rise_phi   = rise[1];
  assign rise_phib  = rise[2];
  assign rise_load  = rise[3];
  assign multi_rise = (rise_phi & rise_phib) | (rise_phi & rise_load) | (rise_phib & rise_load);
  assign rx_state   = state;

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    master_n    = master;
    committed_n = committed;
    cnt_n       = nbits_cnt;
    data_out_n  = data_out;
    valid_n     = 1'b0;
    seq_n       = err_seq;
    count_n     = err_count;
    abort_n     = err_abort;
    if (state == IDLE) begin
      if (rise_id) begin
        state_n     = WAIT_PHI;
        sr_n        = '0;
        cnt_n       = '0;
        committed_n = 1'b0;
        seq_n       = 1'b0;
        count_n     = 1'b0;
        abort_n     = 1'b0;
      end
    end else if (!s1_ctl[0]) begin
      state_n = IDLE;
      if (nbits_cnt != '0 && !committed) abort_n = 1'b1;
    end else if (multi_rise) begin
      seq_n = 1'b1;
    end else if (state == WAIT_PHI) begin
      if (rise_phi) begin
        master_n = s1_data;
        state_n  = WAIT_PHIB;
      end else if (rise_load) begin
        // only the first load of a frame may commit, whether or not it succeeds
        if (committed) begin
          seq_n = 1'b1;
        end else begin
          committed_n = 1'b1;
          if (nbits_cnt == FULL) begin
            data_out_n = sr;
            valid_n    = 1'b1;
          end else begin
            count_n = 1'b1;
          end
        end
      end else if (rise_phib) begin
        seq_n = 1'b1;
      end
    end else begin
      if (rise_phib) begin
        if (nbits_cnt < FULL) begin
          sr_n  = {master, sr[NTX_BITS-1:1]};
          cnt_n = nbits_cnt + 1'b1;
        end else begin
          count_n = 1'b1;
        end
        state_n = WAIT_PHI;
      end else if (rise_phi) begin
        seq_n    = 1'b1;
        master_n = s1_data;
      end else if (rise_load) begin
        seq_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_ctl     <= '0;
      s2_ctl     <= '0;
      s1_data    <= 1'b0;
      state      <= IDLE;
      sr         <= '0;
      master     <= 1'b0;
      committed  <= 1'b0;
      nbits_cnt  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err_seq    <= 1'b0;
      err_count  <= 1'b0;
      err_abort  <= 1'b0;
    end else begin
      s1_ctl     <= {scan_load_chip, scan_phi_bar, scan_phi, scan_id};
      s2_ctl     <= s1_ctl;
      s1_data    <= scan_data_in;
      state      <= state_n;
      sr         <= sr_n;
      master     <= master_n;
      committed  <= committed_n;
      nbits_cnt  <= cnt_n;
      data_out   <= data_out_n;
      data_valid <= valid_n;
      err_seq    <= seq_n;
      err_count  <= count_n;
      err_abort  <= abort_n;
    end
  end

endmodule

// File: tb/tb_hop_scan_rx.sv
// tb/tb_hop_scan_rx.sv - directed bench for hop_scan_rx with a commit scoreboard
module tb_hop_scan_rx;
  localparam int N = 58;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scan_id = 1'b0, scan_phi = 1'b0, scan_phi_bar = 1'b0;
  logic scan_data_in = 1'b0, scan_load_chip = 1'b0;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic [5:0]   nbits_cnt;
  logic [1:0]   rx_state;
  logic         err_seq, err_count, err_abort;

  int errors = 0, checks = 0, cycle = 0;
  int valid_pulses = 0, valid_cycle = -1, load_cycle = 0, pulses0 = 0;
  logic [N-1:0] sb[$];
  logic [N-1:0] w1, w2, w3, w4, w5, exp_w, prev_out;

  hop_scan_rx #(.NTX_BITS(N), .BIT_CNT_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .scan_id(scan_id), .scan_phi(scan_phi),
    .scan_phi_bar(scan_phi_bar), .scan_data_in(scan_data_in), .scan_load_chip(scan_load_chip),
    .data_out(data_out), .data_valid(data_valid), .nbits_cnt(nbits_cnt), .rx_state(rx_state),
    .err_seq(err_seq), .err_count(err_count), .err_abort(err_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid) begin
      valid_pulses++;
      valid_cycle = cycle;
      check("valid_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("data_out", 64'(data_out), 64'(exp_w));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int w);
    scan_data_in = b;
    scan_phi = 1'b1;     tick(w);
    scan_phi = 1'b0;     tick(1);
    scan_phi_bar = 1'b1; tick(w);
    scan_phi_bar = 1'b0; tick(1);
  endtask

  task automatic send_bits(input logic [N-1:0] w, input int first, input int nbits, input int wd);
    for (int i = first; i < nbits; i++) send_bit((i < N) ? w[i] : 1'b1, wd);
  endtask

  task automatic load_pulse(input int w);
    load_cycle = cycle;
    scan_load_chip = 1'b1; tick(w);
    scan_load_chip = 1'b0; tick(3);
  endtask

  task automatic start_frame();
    scan_id = 1'b1; tick(3);
  endtask

  task automatic end_frame();
    tick(2); scan_id = 1'b0; tick(4);
  endtask

  initial begin
    w1 = 58'h2AA_AAAA_5555_5555;
    w2 = 58'h1F0_3C5A_9E21_7B6D;
    w3 = 58'h0C3_1234_5678_9AB1;
    w4 = 58'h35A_F00D_CAFE_0123;
    w5 = 58'h123_4567_89AB_CDEF;

    tick(3);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_nbits", 64'(nbits_cnt), 64'd0);
    check("rst_state", 64'(rx_state), 64'd0);
    check("rst_errs", 64'({err_seq, err_count, err_abort}), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // nominal frame
    start_frame();
    send_bits(w1, 0, N, 1);
    check("nom_nbits", 64'(nbits_cnt), 64'd58);
    pulses0 = valid_pulses;
    sb.push_back(w1);
    load_pulse(1);
    check("nom_latency", 64'(valid_cycle - load_cycle), 64'd2);
    check("nom_one_pulse", 64'(valid_pulses - pulses0), 64'd1);
    check("nom_state", 64'(rx_state), 64'd1);
    check("nom_errs", 64'({err_seq, err_count, err_abort}), 64'd0);
    end_frame();

    // short frame, then a good frame
    start_frame();
    send_bits(w2, 0, N - 1, 1);
    pulses0 = valid_pulses;
    load_pulse(1);
    check("short_err_count", 64'(err_count), 64'd1);
    check("short_no_valid", 64'(valid_pulses - pulses0), 64'd0);
    check("short_hold", 64'(data_out), 64'(w1));
    end_frame();
    start_frame();
    check("rise_id_clears", 64'({err_seq, err_count, err_abort}), 64'd0);
    send_bits(w2, 0, N, 1);
    sb.push_back(w2);
    load_pulse(1);
    check("short_next_errs", 64'(err_count), 64'd0);
    end_frame();

    // phase order: lone phi_bar, then two phi before phi_bar
    start_frame();
    scan_phi_bar = 1'b1; tick(1); scan_phi_bar = 1'b0; tick(2);
    check("seq_phib_err", 64'(err_seq), 64'd1);
    check("seq_phib_nbits", 64'(nbits_cnt), 64'd0);
    scan_data_in = 1'b1; scan_phi = 1'b1; tick(1); scan_phi = 1'b0; tick(1);
    scan_data_in = 1'b0; scan_phi = 1'b1; tick(1); scan_phi = 1'b0; tick(1);
    scan_phi_bar = 1'b1; tick(1); scan_phi_bar = 1'b0; tick(2);
    check("seq_double_phi_nbits", 64'(nbits_cnt), 64'd1);
    send_bits(w3, 1, N, 1);
    sb.push_back({w3[N-1:1], 1'b0});
    load_pulse(1);
    check("seq_sticky", 64'(err_seq), 64'd1);
    end_frame();

    // overflow: 59 bits, then a second load
    start_frame();
    send_bits(w5, 0, N + 1, 1);
    check("ovf_nbits_sat", 64'(nbits_cnt), 64'd58);
    check("ovf_err_count", 64'(err_count), 64'd1);
    pulses0 = valid_pulses;
    sb.push_back(w5);
    load_pulse(1);
    check("ovf_err_seq_clear", 64'(err_seq), 64'd0);
    load_pulse(1);
    check("second_load_seq", 64'(err_seq), 64'd1);
    check("second_load_no_commit", 64'(valid_pulses - pulses0), 64'd1);
    end_frame();

    // abort after 20 bits
    prev_out = data_out;
    pulses0 = valid_pulses;
    start_frame();
    send_bits(w4, 0, 20, 1);
    scan_id = 1'b0; tick(4);
    check("abort_err", 64'(err_abort), 64'd1);
    check("abort_state", 64'(rx_state), 64'd0);
    check("abort_data_hold", 64'(data_out), 64'(prev_out));
    check("abort_no_valid", 64'(valid_pulses - pulses0), 64'd0);

    // stretched pulses
    start_frame();
    check("abort_cleared", 64'(err_abort), 64'd0);
    send_bits(w1, 0, N, 3);
    check("str_nbits", 64'(nbits_cnt), 64'd58);
    pulses0 = valid_pulses;
    sb.push_back(w1);
    load_pulse(3);
    check("str_latency", 64'(valid_cycle - load_cycle), 64'd2);
    check("str_one_pulse", 64'(valid_pulses - pulses0), 64'd1);
    check("str_errs", 64'({err_seq, err_count, err_abort}), 64'd0);
    end_frame();

    // async reset mid-frame, between clock edges
    start_frame();
    send_bits(w4, 0, 10, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    scan_id = 1'b0; scan_phi = 1'b0; scan_phi_bar = 1'b0; scan_load_chip = 1'b0; scan_data_in = 1'b0;
    #1;
    check("arst_data_out", 64'(data_out), 64'd0);
    check("arst_nbits", 64'(nbits_cnt), 64'd0);
    check("arst_state", 64'(rx_state), 64'd0);
    check("arst_valid", 64'(data_valid), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    start_frame();
    send_bits(w4, 0, N, 1);
    sb.push_back(w4);
    load_pulse(1);
    check("arst_frame_errs", 64'({err_seq, err_count, err_abort}), 64'd0);
    end_frame();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
